// File: rtl/bcd_serial_adder.sv
// Purpose: multi-digit packed-BCD adder, one decimal digit per clock, least-significant digit first.
// Latency: start accepted at edge k, done pulses in the cycle after edge k+DIGITS; busy lasts DIGITS cycles.
// Backpressure: none; start is only honoured in IDLE or DONE and ignored while RUN is in progress.
// Ports: clk/rst_n (async active-low) clock and reset; start, a, b, cin request and operands;
//        busy/done status; sum, cout, invalid hold the result until the next accepted start.

// One-digit BCD adder cell: binary add, then +6 correction when the digit overflows decimal range.
module bcd_digit_cell (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [4:0] bin_sum;

  always_comb begin
    bin_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
    if (bin_sum > 5'd9) begin
      s_o = bin_sum[3:0] + 4'd6;
      c_o = 1'b1;
    end else begin
      s_o = bin_sum[3:0];
      c_o = 1'b0;
    end
  end
endmodule

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          invalid_q, invalid_d;

  logic [3:0]    dig_a, dig_b, cell_s;
  logic          cell_c;

  // Any nibble above 9 is not a decimal digit.
  function automatic logic has_bad_nibble(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Select the operand digit pair for the current index.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  bcd_digit_cell u_cell (
    .a_i (dig_a),
    .b_i (dig_b),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d       = a;
          b_d       = b;
          carry_d   = cin;
          sum_d     = '0;
          idx_d     = '0;
          invalid_d = has_bad_nibble(a) | has_bad_nibble(b);
          state_d   = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) sum_d[4*i +: 4] = cell_s;
        end
        carry_d = cell_c;
        if (idx_q == LAST) begin
          // Index stays put on the final digit so it never wraps.
          cout_d  = cell_c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Purpose: directed checks of bcd_serial_adder with DIGITS=4 against hand-computed results.
// Latency: every operation is expected to take 4 busy cycles and then one done cycle.
// Backpressure: none; the bench drives start as a pulse, a held level or on the done cycle.
module tb_bcd_serial_adder;
  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start, then wait (bounded) for done. Returns at #1 after the edge that raised done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        output int busy_cycles, output logic got_done);
    int n;
    a = ta; b = tb; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      n++;
    end
    got_done = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, sum, cout, invalid} !== 20'h0)
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
               busy, done, sum, cout, invalid);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_basic();
    int bc; logic gd;
    run_op(16'h1234, 16'h5678, 1'b0, bc, gd);
    n_checks++;
    if (bc !== 4 || gd !== 1'b1)
      $display("FAIL basic_latency: busy_cycles=%0d done=%b, want 4 1", bc, gd);
    else n_pass++;
    n_checks++;
    if (sum !== 16'h6912 || cout !== 1'b0 || invalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_result: sum=%h cout=%b inv=%b busy=%b, want 6912 0 0 0",
               sum, cout, invalid, busy);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || sum !== 16'h6912)
      $display("FAIL basic_done_pulse: done=%b sum=%h, want 0 6912", done, sum);
    else n_pass++;
  endtask

  task automatic test_carry();
    int bc; logic gd;
    run_op(16'h9999, 16'h0001, 1'b0, bc, gd);
    n_checks++;
    if (!gd || sum !== 16'h0000 || cout !== 1'b1)
      $display("FAIL carry_ripple: done=%b sum=%h cout=%b, want 1 0000 1", gd, sum, cout);
    else n_pass++;
    @(posedge clk); #1;
    run_op(16'h0000, 16'h0000, 1'b1, bc, gd);
    n_checks++;
    if (!gd || bc !== 4 || sum !== 16'h0001 || cout !== 1'b0)
      $display("FAIL carry_cin: done=%b bc=%0d sum=%h cout=%b, want 1 4 0001 0",
               gd, bc, sum, cout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int bc; logic gd; int n;
    run_op(16'h5000, 16'h5000, 1'b0, bc, gd);
    n_checks++;
    if (!gd || sum !== 16'h0000 || cout !== 1'b1)
      $display("FAIL b2b_first: done=%b sum=%h cout=%b, want 1 0000 1", gd, sum, cout);
    else n_pass++;
    // Start again during the done cycle.
    a = 16'h0999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cout !== 1'b1)
      $display("FAIL b2b_accept: busy=%b done=%b cout=%b, want 1 0 1 (cout held)",
               busy, done, cout);
    else n_pass++;
    bc = 0; n = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (!done || bc !== 4 || sum !== 16'h1000 || cout !== 1'b0)
      $display("FAIL b2b_second: done=%b bc=%0d sum=%h cout=%b, want 1 4 1000 0",
               done, bc, sum, cout);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_start_held();
    int dones;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Keep start high and scramble operands while RUN is active.
    a = 16'h9999; b = 16'h9999; cin = 1'b1;
    dones = 0;
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 1)
      $display("FAIL held_done_count: got %0d dones, want 1", dones);
    else n_pass++;
    n_checks++;
    if (sum !== 16'h3333 || cout !== 1'b0)
      $display("FAIL held_result: sum=%h cout=%b, want 3333 0", sum, cout);
    else n_pass++;
  endtask

  task automatic test_invalid();
    int bc; logic gd;
    a = 16'h00A0; b = 16'h0000; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (invalid !== 1'b1 || busy !== 1'b1)
      $display("FAIL invalid_accept: inv=%b busy=%b, want 1 1", invalid, busy);
    else n_pass++;
    bc = 0;
    for (int n = 0; n < 20 && !done; n++) begin
      if (busy) bc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!done || bc !== 4 || sum !== 16'h0100 || cout !== 1'b0 || invalid !== 1'b1)
      $display("FAIL invalid_result: done=%b bc=%0d sum=%h cout=%b inv=%b, want 1 4 0100 0 1",
               done, bc, sum, cout, invalid);
    else n_pass++;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (invalid !== 1'b1 || sum !== 16'h0100)
      $display("FAIL invalid_hold: inv=%b sum=%h, want 1 0100", invalid, sum);
    else n_pass++;
    a = 16'h0003; b = 16'h0004; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (invalid !== 1'b0)
      $display("FAIL invalid_clear: inv=%b, want 0", invalid);
    else n_pass++;
    for (int n = 0; n < 20 && !done; n++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int bc; logic gd; int dones;
    run_op(16'h9999, 16'h0001, 1'b0, bc, gd);   // leaves cout=1
    @(posedge clk); #1;
    a = 16'hF234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (sum !== 16'h0012 || invalid !== 1'b1 || cout !== 1'b1 || busy !== 1'b1)
      $display("FAIL rst_mid_partial: sum=%h inv=%b cout=%b busy=%b, want 0012 1 1 1",
               sum, invalid, cout, busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, sum, cout, invalid} !== 20'h0)
      $display("FAIL rst_mid_clear: busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
               busy, done, sum, cout, invalid);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0)
      $display("FAIL rst_mid_no_done: %0d active cycles after reset, want 0", dones);
    else n_pass++;
    run_op(16'h0005, 16'h0004, 1'b0, bc, gd);
    n_checks++;
    if (!gd || bc !== 4 || sum !== 16'h0009 || cout !== 1'b0 || invalid !== 1'b0)
      $display("FAIL rst_mid_recover: done=%b bc=%0d sum=%h cout=%b inv=%b, want 1 4 0009 0 0",
               gd, bc, sum, cout, invalid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_start_held();
    test_invalid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Multi-digit packed-BCD adder that processes one decimal digit per clock, least-significant digit first. Each digit step is computed by the team's existing one-digit BCD adder cell: 4-bit a, 4-bit b and cin in; 4-bit sum and decimal carry out. This block is the sequencing stage directly upstream of that cell. It latches two DIGITS-wide operands, feeds digit pairs and the registered carry to the cell, and assembles the result.

Parameters:
DIGITS, 4, number of BCD digits per operand; legal range 1..8.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request to begin an addition; sampled on rising edge.
a  input  4*DIGITS  operand A, packed BCD; digit i is a[4i+3:4i].
b  input  4*DIGITS  operand B, packed BCD.
cin  input  1  initial carry into digit 0.
busy  output  1  high while digits are being processed.
done  output  1  single-cycle pulse when result is complete.
sum  output  4*DIGITS  packed BCD result.
cout  output  1  decimal carry out of the most significant digit.
invalid  output  1  high if any latched operand nibble was greater than 9.

Behaviour:
- Reset (rst_n low, asynchronous, at any time, including mid-operation): state IDLE; busy=0, done=0, sum=0, cout=0, invalid=0, digit index=0, carry register=0, operand registers=0. The operation in progress is abandoned.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge accepts a request:
  - latch a, b into operand registers; latch cin into the carry register;
  - clear sum to 0; set index=0;
  - invalid = 1 if any nibble of a or b is greater than 9, else 0;
  - go to RUN.
- RUN: busy=1 throughout. Each edge:
  - the digit cell receives operand digit[index] of A, digit[index] of B and the carry register;
  - sum nibble[index] <= cell sum; carry register <= cell cout; index <= index+1.
  - On the edge that processes index=DIGITS-1: cout <= cell cout, go to DONE.
- DONE: busy=0, done=1 for exactly one cycle. At the next edge go to IDLE.
  - If start=1 at that edge, the request is accepted exactly as from IDLE and the state goes directly to RUN. Back-to-back operations are allowed.
- start is ignored while in RUN; operand and cin changes during RUN have no effect.
- Latency: start accepted at edge k; done is high in the cycle following edge k+DIGITS. busy is high for exactly DIGITS cycles.
- sum, cout and invalid hold their values from done until the next accepted start. sum nibbles change progressively during RUN.
- cout is not updated until the final digit; it holds the previous result's value during RUN.
- Arithmetic: each digit step follows the BCD cell rule.
  - binary 5-bit sum s = a_i + b_i + c;
  - if s > 9 (or binary carry out), then digit = (s + 6) mod 16 and carry = 1; otherwise digit = s and carry = 0.
  - With invalid inputs the same rule is still applied; results are deterministic but not decimal-meaningful. invalid flags this condition.
- Index width is ceil(log2(DIGITS)), minimum 1 bit; the index never wraps during RUN.

Test Plan:
- DIGITS=4: a=0x1234, b=0x5678, cin=0, start pulse -> busy high 4 cycles; done one cycle later; sum=0x6912, cout=0, invalid=0.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all digits); a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- a=0x5000, b=0x5000 then, on the done cycle, start again with a=0x0999, b=0x0001 -> first result sum=0x0000, cout=1; second accepted without an IDLE cycle, sum=0x1000, cout=0.
- start held high and a/b changed during RUN -> ignored; result matches operands latched at acceptance; exactly one done per accepted start.
- a=0x00A0, b=0x0000 -> invalid=1 from acceptance through the next start; done still asserted at the normal latency.
- rst_n pulsed low after 2 digit cycles -> busy, done, sum, cout, invalid immediately 0; no done follows; a new start afterwards completes correctly.
